// File: rtl/tcdm_bank_arb_pkg.sv
// Shared types and helpers for the TCDM bank arbiter.
// The TCDM_BANK_ARB_LOCK_EN macro controls whether the lock state type is used.
package tcdm_bank_arb_pkg;

  localparam int DefAddrWidth = 32;
  localparam int DefDataWidth = 32;
  localparam int DefBeWidth   = DefDataWidth / 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] add;
    logic                    wen;
    logic [DefDataWidth-1:0] wdata;
    logic [DefBeWidth-1:0]   be;
  } bank_req_t;

  // Index width for n items; a single item still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_rr_pick.sv
// Combinational round-robin find-first: first set request at or after i_ptr,
// searching upward modulo NumPorts.
module tcdm_rr_pick
  import tcdm_bank_arb_pkg::*;
#(
  parameter int NumPorts = 4,
  parameter int IdxW     = idx_w(NumPorts)
) (
  input  logic [NumPorts-1:0] i_req,
  input  logic [IdxW-1:0]     i_ptr,
  output logic [NumPorts-1:0] o_gnt,
  output logic [IdxW-1:0]     o_idx,
  output logic                o_valid
);

  localparam int SumW = IdxW + 1;

  logic [SumW-1:0] w_sum  [NumPorts];
  logic [IdxW-1:0] w_cand [NumPorts];

  // w_cand[gi] is the port gi steps after the pointer; ptr and gi are both
  // below NumPorts, so a single conditional subtract performs the modulo.
  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_cand
    assign w_sum[gi]  = {1'b0, i_ptr} + SumW'(gi);
    assign w_cand[gi] = (w_sum[gi] >= SumW'(NumPorts))
                      ? IdxW'(w_sum[gi] - SumW'(NumPorts))
                      : IdxW'(w_sum[gi]);
  end

  // Walk from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (i_req[w_cand[i]]) begin
        o_idx   = w_cand[i];
        o_valid = 1'b1;
      end
    end
  end

  assign o_gnt = o_valid ? (NumPorts'(1) << o_idx) : '0;

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one single-ported TCDM bank among NumPorts requesters.
// Define TCDM_BANK_ARB_LOCK_EN to add lock_i and the owner-lock FSM for atomic sequences.
module tcdm_bank_arbiter
  import tcdm_bank_arb_pkg::*;
#(
  parameter int NumPorts  = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int BeWidth   = DataWidth / 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumPorts-1:0]                req_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0] add_i,
  input  logic [NumPorts-1:0]                wen_i,
  input  logic [NumPorts-1:0][DataWidth-1:0] wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]   be_i,
`ifdef TCDM_BANK_ARB_LOCK_EN
  input  logic [NumPorts-1:0]                lock_i,
`endif
  output logic [NumPorts-1:0]                gnt_o,
  output logic [NumPorts-1:0]                r_valid_o,
  output logic [DataWidth-1:0]               r_rdata_o,
  output logic                               bank_req_o,
  output logic [AddrWidth-1:0]               bank_add_o,
  output logic                               bank_wen_o,
  output logic [DataWidth-1:0]               bank_wdata_o,
  output logic [BeWidth-1:0]                 bank_be_o,
  input  logic [DataWidth-1:0]               bank_rdata_i
);

  localparam int IdxW = idx_w(NumPorts);

  logic [IdxW-1:0]     r_rr_q;
  logic [IdxW-1:0]     r_resp_idx_q;
  logic                r_resp_v_q;
  logic [NumPorts-1:0] w_req;
  logic [NumPorts-1:0] w_gnt;
  logic [IdxW-1:0]     w_idx;
  logic                w_valid;
  logic [IdxW-1:0]     w_rr_next;

`ifdef TCDM_BANK_ARB_LOCK_EN
  lock_state_e     r_state_q, w_state_d;
  logic [IdxW-1:0] r_owner_q, w_owner_d;

  // While locked only the owner is visible to the picker.
  assign w_req = (r_state_q == LOCKED) ? (req_i & (NumPorts'(1) << r_owner_q)) : req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= UNLOCKED;
      r_owner_q <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_owner_q <= w_owner_d;
    end
  end

  always_comb begin
    w_state_d = r_state_q;
    w_owner_d = r_owner_q;
    case (r_state_q)
      UNLOCKED: begin
        if (w_valid && lock_i[w_idx]) begin
          w_state_d = LOCKED;
          w_owner_d = w_idx;
        end
      end
      LOCKED: begin
        if (w_valid && !lock_i[r_owner_q]) begin
          w_state_d = UNLOCKED;
        end
      end
      default: w_state_d = UNLOCKED;
    endcase
  end
`else
  assign w_req = req_i;
`endif

  tcdm_rr_pick #(
    .NumPorts (NumPorts),
    .IdxW     (IdxW)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_q),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // While locked, every grant goes to the owner, so winner+1 equals the
  // pointer already set on lock entry: the pointer stays frozen.
  assign w_rr_next = (w_idx == IdxW'(NumPorts - 1)) ? '0 : (w_idx + IdxW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_q       <= '0;
      r_resp_v_q   <= 1'b0;
      r_resp_idx_q <= '0;
    end else begin
      r_resp_v_q <= w_valid;
      if (w_valid) begin
        r_rr_q       <= w_rr_next;
        r_resp_idx_q <= w_idx;
      end
    end
  end

  assign gnt_o        = w_gnt;
  assign bank_req_o   = |w_req;
  assign bank_add_o   = add_i[w_idx];
  assign bank_wen_o   = wen_i[w_idx];
  assign bank_wdata_o = wdata_i[w_idx];
  assign bank_be_o    = be_i[w_idx];

  assign r_valid_o = r_resp_v_q ? (NumPorts'(1) << r_resp_idx_q) : '0;
  assign r_rdata_o = bank_rdata_i;

endmodule
